// File: rtl/fp_pkg.sv
// Shared definitions for the FP result pipeline.
//   rm_e      : rounding-mode encoding (RNE=0, RTZ=1, RUP=2, RDN=3)
//   FP_EXP_W  : default exponent field width
//   FP_MAN_W  : default stored mantissa width
//   FLAG_OVF / FLAG_INX : bit positions inside the 2-bit flags vector
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  localparam int FP_EXP_W = 5;
  localparam int FP_MAN_W = 10;

  localparam int FLAG_OVF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision, purely combinational.
//   grs     : {guard, round, sticky}
//   man_lsb : lsb of the pre-rounding mantissa (tie-to-even)
//   sign    : result sign (directed modes)
//   rm      : rounding mode, present only with FP_ROUND_MODES_EN
//   inc     : 1 when the mantissa must be incremented
// Build option: FP_ROUND_MODES_EN selects all four modes; without it only
// round-to-nearest-even is implemented and the rm port does not exist.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic [2:0] grs,
  input  logic       man_lsb,
  input  logic       sign,
`ifdef FP_ROUND_MODES_EN
  input  rm_e        rm,
`endif
  output logic       inc
);

  logic g;
  logic any_lost;

  assign g        = grs[2];
  assign any_lost = |grs;

`ifdef FP_ROUND_MODES_EN
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (grs[1] | grs[0] | man_lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & any_lost;
      RM_RDN:  inc = sign & any_lost;
      default: inc = 1'b0;
    endcase
  end
`else
  logic unused_sign_lost;
  assign unused_sign_lost = sign ^ any_lost;
  assign inc = g & (grs[1] | grs[0] | man_lsb);
`endif

endmodule

// File: rtl/fp_result_pipe.sv
// Two-stage rounding / packing pipeline for an FP adder result.
//   Stage 1 registers sign, e1 = exp+carry, mantissa and the round increment.
//   Stage 2 applies the increment, handles mantissa carry-out and overflow,
//   and holds the packed {sign, exp, man} result plus {overflow, inexact}.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : input handshake
//   exp, carry, man, grs  : pre-normalised operand fields
//   a_sign, b_sign, swap  : sign selection (swap=1 -> b_sign)
//   rm                    : rounding mode (honoured only with FP_ROUND_MODES_EN)
//   out_valid / out_ready : output handshake
//   result, flags         : packed result and {overflow, inexact}
// Build option: FP_ROUND_MODES_EN enables RTZ/RUP/RDN; otherwise RNE is forced
// and no rounding-mode state is kept.
module fp_result_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = FP_EXP_W,
  parameter  int MAN_W = FP_MAN_W,
  localparam int RES_W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp,
  input  logic             carry,
  input  logic [MAN_W-1:0] man,
  input  logic [2:0]       grs,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic             swap,
  input  logic [1:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic [1:0]       flags
);

  // Exponent after carry fits EXP_W+1 bits; one more bit absorbs the
  // mantissa rounding carry.
  localparam int E2_W = EXP_W + 2;
  localparam logic [E2_W-1:0] EXP_OVF = E2_W'((1 << EXP_W) - 1);

  // ---------------- stage 1 state ----------------
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [EXP_W:0]   s1_e1_q,    s1_e1_d;
  logic [MAN_W-1:0] s1_man_q,   s1_man_d;
  logic             s1_inc_q,   s1_inc_d;
  logic             s1_inx_q,   s1_inx_d;
`ifdef FP_ROUND_MODES_EN
  rm_e              s1_rm_q,    s1_rm_d;
`endif

  // ---------------- stage 2 state ----------------
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] result_q,    result_d;
  logic [1:0]       flags_q,     flags_d;

  logic in_sign;
  logic in_inc;
  logic s2_adv;
  logic in_xfer;

  assign in_sign = swap ? b_sign : a_sign;

  // Output stage can take new data when empty or draining this edge;
  // stage 1 can accept when empty or moving on.
  assign s2_adv   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_xfer  = in_valid & in_ready;

`ifdef FP_ROUND_MODES_EN
  fp_round_inc u_round_inc (
    .grs     (grs),
    .man_lsb (man[0]),
    .sign    (in_sign),
    .rm      (rm_e'(rm)),
    .inc     (in_inc)
  );
`else
  logic unused_rm;
  assign unused_rm = ^rm;

  fp_round_inc u_round_inc (
    .grs     (grs),
    .man_lsb (man[0]),
    .sign    (in_sign),
    .inc     (in_inc)
  );
`endif

  // ---------------- stage 1 next state ----------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_e1_d    = s1_e1_q;
    s1_man_d   = s1_man_q;
    s1_inc_d   = s1_inc_q;
    s1_inx_d   = s1_inx_q;
`ifdef FP_ROUND_MODES_EN
    s1_rm_d    = s1_rm_q;
`endif
    if (in_ready) s1_valid_d = in_valid;
    if (in_xfer) begin
      s1_sign_d = in_sign;
      s1_e1_d   = {1'b0, exp} + (EXP_W+1)'(carry);
      s1_man_d  = man;
      s1_inc_d  = in_inc;
      s1_inx_d  = |grs;
`ifdef FP_ROUND_MODES_EN
      s1_rm_d   = rm_e'(rm);
`endif
    end
  end

  // ---------------- stage 2 datapath ----------------
  logic [MAN_W:0]   m2;
  logic [E2_W-1:0]  e2;
  logic             ovf;
  logic             to_inf;
  logic [RES_W-1:0] packed_res;

  always_comb begin
    m2 = {1'b0, s1_man_q} + (MAN_W+1)'(s1_inc_q);
    // Mantissa wrap-around (all-ones + 1) bumps the exponent; m2 low bits
    // are already zero in that case.
    e2  = {1'b0, s1_e1_q} + E2_W'(m2[MAN_W]);
    ovf = (e2 >= EXP_OVF);

`ifdef FP_ROUND_MODES_EN
    case (s1_rm_q)
      RM_RNE:  to_inf = 1'b1;
      RM_RUP:  to_inf = ~s1_sign_q;
      RM_RDN:  to_inf = s1_sign_q;
      default: to_inf = 1'b0;
    endcase
`else
    to_inf = 1'b1;
`endif

    if (!ovf)
      packed_res = {s1_sign_q, e2[EXP_W-1:0], m2[MAN_W-1:0]};
    else if (to_inf)
      packed_res = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      packed_res = {s1_sign_q, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
  end

  // ---------------- stage 2 next state ----------------
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d           = packed_res;
        flags_d[FLAG_OVF]  = ovf;
        flags_d[FLAG_INX]  = s1_inx_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_e1_q     <= '0;
      s1_man_q    <= '0;
      s1_inc_q    <= 1'b0;
      s1_inx_q    <= 1'b0;
`ifdef FP_ROUND_MODES_EN
      s1_rm_q     <= RM_RNE;
`endif
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_e1_q     <= s1_e1_d;
      s1_man_q    <= s1_man_d;
      s1_inc_q    <= s1_inc_d;
      s1_inx_q    <= s1_inx_d;
`ifdef FP_ROUND_MODES_EN
      s1_rm_q     <= s1_rm_d;
`endif
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_result_pipe.sv
// Self-checking bench for fp_result_pipe: directed table, randomized traffic
// against a magnitude-arithmetic reference model, stall and reset sequences.
module tb_fp_result_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int RES_W = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_i;
  logic             carry_i;
  logic [MAN_W-1:0] man_i;
  logic [2:0]       grs_i;
  logic             a_sign_i, b_sign_i, swap_i;
  logic [1:0]       rm_i;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic [1:0]       flags;

  fp_result_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp(exp_i), .carry(carry_i), .man(man_i), .grs(grs_i),
    .a_sign(a_sign_i), .b_sign(b_sign_i), .swap(swap_i), .rm(rm_i),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] e; logic c; logic [9:0] m; logic [2:0] g;
    logic as; logic bs; logic sw; logic [1:0] rm;
    logic [15:0] res; logic [1:0] fl;
  } vec_t;

  typedef struct { logic [15:0] res; logic [1:0] fl; int acc; bit lat; } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] cur_res; logic [1:0] cur_fl; bit cur_lat;
  bit   rand_ready = 0;
  bit   hold_vld = 0; logic [15:0] hold_res; logic [1:0] hold_fl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] e, input logic c, input logic [9:0] m,
                              input logic [2:0] g, input logic as, input logic bs,
                              input logic sw, input logic [1:0] rm,
                              input logic [15:0] res, input logic [1:0] fl);
    vec_t v;
    v.e = e; v.c = c; v.m = m; v.g = g; v.as = as; v.bs = bs; v.sw = sw; v.rm = rm;
    v.res = res; v.fl = fl;
    return v;
  endfunction

  // Reference: treat {exponent, mantissa} as one magnitude integer, so a
  // rounding carry flows into the exponent by plain addition.
  function automatic logic [17:0] model(input vec_t v);
    int e, mag, lim; bit s, g, lost, inc, ovf, inf; int rmv;
    logic [15:0] r;
    s    = v.sw ? v.bs : v.as;
    g    = v.g[2];
    lost = (v.g != 3'b000);
`ifdef FP_ROUND_MODES_EN
    rmv = v.rm;
`else
    rmv = 0;
`endif
    case (rmv)
      0: inc = g && (v.g[1] || v.g[0] || v.m[0]);
      1: inc = 0;
      2: inc = !s && lost;
      default: inc = s && lost;
    endcase
    e   = v.e + v.c;
    mag = e * (1 << MAN_W) + v.m + inc;
    lim = ((1 << EXP_W) - 1) * (1 << MAN_W);
    ovf = (mag >= lim);
    inf = (rmv == 0) || (rmv == 2 && !s) || (rmv == 3 && s);
    if (!ovf)     r = {s, 15'(mag)};
    else if (inf) r = {s, 15'h7C00};
    else          r = {s, 15'h7BFF};
    return {ovf, lost || ovf, r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard, sampling at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      hold_vld = 0;
    end else begin
      if (out_valid && hold_vld) begin
        chk("hold_result", result, hold_res);
        chk("hold_flags", flags, hold_fl);
      end
      hold_vld = out_valid && !out_ready;
      hold_res = result; hold_fl = flags;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %0h want none", result);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("flags", flags, e.fl);
          if (e.lat) chk("latency", cyc - e.acc, 2);
        end
      end
      if (in_valid && in_ready) sbq.push_back('{cur_res, cur_fl, cyc, cur_lat});
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input vec_t v, input bit lat);
    exp_i = v.e; carry_i = v.c; man_i = v.m; grs_i = v.g;
    a_sign_i = v.as; b_sign_i = v.bs; swap_i = v.sw; rm_i = v.rm;
    cur_res = v.res; cur_fl = v.fl; cur_lat = lat;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input bit lat);
    int w = 0;
    drive(v, lat);
    @(negedge clk);
    while (!in_ready && w < 200) begin w++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 1000) begin w++; @(negedge clk); end
    if (sbq.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [17:0] mr;
    rst_n = 1'b0; in_valid = 0; exp_i = 0; carry_i = 0; man_i = 0; grs_i = 0;
    a_sign_i = 0; b_sign_i = 0; swap_i = 0; rm_i = 0; out_ready = 1'b1;
    cur_res = 0; cur_fl = 0; cur_lat = 0;

    //            e     c  m       g       as bs sw rm    res       fl
    tbl.push_back(mk(15, 0, 10'h3FF, 3'b100, 0, 0, 0, 0, 16'h4000, 2'b01));
    tbl.push_back(mk(15, 0, 10'h000, 3'b100, 0, 0, 0, 0, 16'h3C00, 2'b01));
    tbl.push_back(mk(15, 0, 10'h001, 3'b100, 0, 0, 0, 0, 16'h3C02, 2'b01));
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 1, 0, 0, 0, 16'hFC00, 2'b11));
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 1, 0, 1, 0, 16'h7C00, 2'b11));
    tbl.push_back(mk(10, 0, 10'h155, 3'b000, 0, 0, 0, 0, 16'h2955, 2'b00));
    tbl.push_back(mk(30, 0, 10'h3FF, 3'b110, 0, 0, 0, 0, 16'h7C00, 2'b11));
    tbl.push_back(mk(30, 0, 10'h3FE, 3'b011, 0, 0, 0, 0, 16'h7BFE, 2'b01));
    tbl.push_back(mk( 1, 0, 10'h000, 3'b000, 0, 1, 1, 0, 16'h8400, 2'b00));
`ifdef FP_ROUND_MODES_EN
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 0, 0, 0, 1, 16'h7BFF, 2'b11));
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 1, 0, 0, 2, 16'hFBFF, 2'b11));
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 1, 0, 0, 3, 16'hFC00, 2'b11));
    tbl.push_back(mk(15, 0, 10'h000, 3'b001, 0, 0, 0, 2, 16'h3C01, 2'b01));
    tbl.push_back(mk(15, 0, 10'h3FF, 3'b111, 0, 0, 0, 1, 16'h3FFF, 2'b01));
`else
    // rm must be ignored: RTZ encoding still rounds to nearest even.
    tbl.push_back(mk(30, 1, 10'h000, 3'b000, 0, 0, 0, 1, 16'h7C00, 2'b11));
    tbl.push_back(mk(15, 0, 10'h3FF, 3'b111, 0, 0, 0, 1, 16'h4000, 2'b01));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, unstalled: checks value and 2-cycle latency.
    foreach (tbl[i]) send(tbl[i], 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    @(posedge clk); #1;
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      v.e = 5'($urandom_range(0, 31)); v.c = 1'($urandom);
      v.m = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      v.g = 3'($urandom); v.as = 1'($urandom); v.bs = 1'($urandom);
      v.sw = 1'($urandom); v.rm = 2'($urandom);
      mr = model(v);
      v.res = mr[15:0]; v.fl = mr[17:16];
      send(v, 1'b0);
    end
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Backpressure: two accepted, third blocked, all emitted in order.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(mk(3, 0, 10'h011, 3'b000, 0, 0, 0, 0, 16'h0C11, 2'b00), 1'b0);
    send(mk(4, 0, 10'h022, 3'b000, 1, 0, 0, 0, 16'h9022, 2'b00), 1'b0);
    drive(mk(5, 0, 10'h033, 3'b010, 0, 0, 0, 0, 16'h1433, 2'b01), 1'b0);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    @(negedge clk);
    chk("stall_in_ready2", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(mk(5, 0, 10'h033, 3'b010, 0, 0, 0, 0, 16'h1433, 2'b01), 1'b0);
    drain();

    // Reset with two results in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(mk(7, 0, 10'h0AA, 3'b000, 0, 0, 0, 0, 16'h1CAA, 2'b00), 1'b0);
    send(mk(8, 0, 10'h0BB, 3'b000, 0, 0, 0, 0, 16'h20BB, 2'b00), 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(mk(9, 0, 10'h0CC, 3'b100, 0, 0, 0, 0, 16'h24CC, 2'b01), 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
